// File: rtl/mailbox_fifo_ctrl.sv
// mailbox_fifo_ctrl: two-hart mailbox, one message FIFO per direction.
// Ports: clk, resetn; per side x in {a,b}: x_write_in, x_read_in, x_addr,
//   x_wdata in; x_ready, x_rdata, x_msg_irq, x_ack_irq out.
module mailbox_fifo_ctrl #(
   parameter int MSG_WORDS  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int A_HART_ID  = 0,
   parameter int B_HART_ID  = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        a_write_in,
   input  logic        a_read_in,
   input  logic [5:0]  a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_ready,
   output logic [31:0] a_rdata,
   output logic        a_msg_irq,
   output logic        a_ack_irq,
   input  logic        b_write_in,
   input  logic        b_read_in,
   input  logic [5:0]  b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_ready,
   output logic [31:0] b_rdata,
   output logic        b_msg_irq,
   output logic        b_ack_irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int WW = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
   localparam logic [3:0] NWORDS  = 4'(MSG_WORDS);
   localparam logic [4:0] DEPTH5  = 5'(FIFO_DEPTH);
   localparam logic [7:0] DEPTH8  = 8'(FIFO_DEPTH);
   localparam logic [7:0] NWORDS8 = 8'(MSG_WORDS);

   typedef logic [MSG_WORDS-1:0][31:0] msg_t;
   typedef logic [PW:0] ptr_t;
   typedef enum logic [1:0] {P_IDLE, P_ACK, P_WAIT} port_state_t;

   // ---------------- access handshake, per side ----------------
   port_state_t a_state, a_state_n;
   port_state_t b_state, b_state_n;
   logic        a_strobe, b_strobe;
   logic        a_take, b_take;
   logic        a_req, b_req;
   logic        a_is_wr, b_is_wr;
   logic [3:0]  a_idx, b_idx;
   logic [31:0] a_data, b_data;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{a_addr[1:0], b_addr[1:0]};

   assign a_strobe = a_write_in | a_read_in;
   assign b_strobe = b_write_in | b_read_in;
   assign a_take   = (a_state == P_IDLE) & a_strobe;
   assign b_take   = (b_state == P_IDLE) & b_strobe;

   // The request is latched when sampled so the ready cycle acts on a
   // stable copy; write wins when both strobes are high.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_state <= P_IDLE;
         b_state <= P_IDLE;
         a_is_wr <= 1'b0;
         b_is_wr <= 1'b0;
         a_idx   <= 4'd0;
         b_idx   <= 4'd0;
         a_data  <= 32'd0;
         b_data  <= 32'd0;
      end else begin
         a_state <= a_state_n;
         b_state <= b_state_n;
         if (a_take) begin
            a_is_wr <= a_write_in;
            a_idx   <= a_addr[5:2];
            a_data  <= a_wdata;
         end
         if (b_take) begin
            b_is_wr <= b_write_in;
            b_idx   <= b_addr[5:2];
            b_data  <= b_wdata;
         end
      end
   end

   always_comb begin
      a_state_n = a_state;
      a_req     = 1'b0;
      unique case (a_state)
         P_IDLE: if (a_strobe) a_state_n = P_ACK;
         P_ACK: begin
            a_req     = 1'b1;
            a_state_n = a_strobe ? P_WAIT : P_IDLE;
         end
         P_WAIT: if (!a_strobe) a_state_n = P_IDLE;
         default: a_state_n = P_IDLE;
      endcase
   end

   always_comb begin
      b_state_n = b_state;
      b_req     = 1'b0;
      unique case (b_state)
         P_IDLE: if (b_strobe) b_state_n = P_ACK;
         P_ACK: begin
            b_req     = 1'b1;
            b_state_n = b_strobe ? P_WAIT : P_IDLE;
         end
         P_WAIT: if (!b_strobe) b_state_n = P_IDLE;
         default: b_state_n = P_IDLE;
      endcase
   end

   assign a_ready = a_req;
   assign b_ready = b_req;

   // ---------------- write decode, active in the ready cycle ----------------
   function automatic logic in_msg(input logic [3:0] idx);
      return {1'b0, idx[2:0]} < NWORDS;
   endfunction

   logic a_wr, a_commit, a_pop, a_en_wr, a_flag_wr, a_stage_wr;
   logic b_wr, b_commit, b_pop, b_en_wr, b_flag_wr, b_stage_wr;

   assign a_wr       = a_req & a_is_wr;
   assign a_commit   = a_wr & (a_idx == 4'h4);
   assign a_pop      = a_wr & (a_idx == 4'h5);
   assign a_en_wr    = a_wr & (a_idx == 4'h6);
   assign a_flag_wr  = a_wr & (a_idx == 4'h7);
   assign a_stage_wr = a_wr & a_idx[3] & in_msg(a_idx);

   assign b_wr       = b_req & b_is_wr;
   assign b_commit   = b_wr & (b_idx == 4'h4);
   assign b_pop      = b_wr & (b_idx == 4'h5);
   assign b_en_wr    = b_wr & (b_idx == 4'h6);
   assign b_flag_wr  = b_wr & (b_idx == 4'h7);
   assign b_stage_wr = b_wr & b_idx[3] & in_msg(b_idx);

   // ---------------- FIFOs: ab carries A->B, ba carries B->A ----------------
   ptr_t ab_wptr, ab_rptr, ba_wptr, ba_rptr;
   ptr_t ab_count, ba_count;
   logic ab_full, ab_empty, ba_full, ba_empty;
   logic ab_push, ab_pull, ba_push, ba_pull;
   msg_t ab_mem [FIFO_DEPTH];
   msg_t ba_mem [FIFO_DEPTH];
   msg_t a_stage, b_stage;

   assign ab_count = ab_wptr - ab_rptr;
   assign ba_count = ba_wptr - ba_rptr;
   assign ab_empty = (ab_wptr == ab_rptr);
   assign ba_empty = (ba_wptr == ba_rptr);
   assign ab_full  = (ab_wptr[PW] != ab_rptr[PW]) &&
                     (ab_wptr[PW-1:0] == ab_rptr[PW-1:0]);
   assign ba_full  = (ba_wptr[PW] != ba_rptr[PW]) &&
                     (ba_wptr[PW-1:0] == ba_rptr[PW-1:0]);

   // Full is judged on pre-pop pointers, so a commit racing a pop on a
   // full queue is still dropped.
   assign ab_push = a_commit & ~ab_full;
   assign ab_pull = b_pop & ~ab_empty;
   assign ba_push = b_commit & ~ba_full;
   assign ba_pull = a_pop & ~ba_empty;

   // Message storage needs no reset: an empty queue never exposes it.
   always_ff @(posedge clk) begin
      if (ab_push) ab_mem[ab_wptr[PW-1:0]] <= a_stage;
      if (ba_push) ba_mem[ba_wptr[PW-1:0]] <= b_stage;
   end

   // ---------------- control and status state ----------------
   logic [1:0] a_en, b_en;
   logic       a_ack, a_ovf, a_unf;
   logic       b_ack, b_ovf, b_unf;

   // Sticky flags: a W1C loses against a set in the same cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ab_wptr   <= '0;
         ab_rptr   <= '0;
         ba_wptr   <= '0;
         ba_rptr   <= '0;
         a_stage   <= '0;
         b_stage   <= '0;
         a_en      <= 2'd0;
         b_en      <= 2'd0;
         a_ack     <= 1'b0;
         a_ovf     <= 1'b0;
         a_unf     <= 1'b0;
         b_ack     <= 1'b0;
         b_ovf     <= 1'b0;
         b_unf     <= 1'b0;
         a_msg_irq <= 1'b0;
         a_ack_irq <= 1'b0;
         b_msg_irq <= 1'b0;
         b_ack_irq <= 1'b0;
      end else begin
         if (ab_push) ab_wptr <= ab_wptr + ptr_t'(1);
         if (ab_pull) ab_rptr <= ab_rptr + ptr_t'(1);
         if (ba_push) ba_wptr <= ba_wptr + ptr_t'(1);
         if (ba_pull) ba_rptr <= ba_rptr + ptr_t'(1);
         if (a_stage_wr) a_stage[a_idx[WW-1:0]] <= a_data;
         if (b_stage_wr) b_stage[b_idx[WW-1:0]] <= b_data;
         if (a_en_wr) a_en <= a_data[1:0];
         if (b_en_wr) b_en <= b_data[1:0];
         a_ack <= (a_ack & ~(a_flag_wr & a_data[1])) | ab_pull;
         a_ovf <= (a_ovf & ~(a_flag_wr & a_data[2])) | (a_commit & ab_full);
         a_unf <= (a_unf & ~(a_flag_wr & a_data[3])) | (a_pop & ba_empty);
         b_ack <= (b_ack & ~(b_flag_wr & b_data[1])) | ba_pull;
         b_ovf <= (b_ovf & ~(b_flag_wr & b_data[2])) | (b_commit & ba_full);
         b_unf <= (b_unf & ~(b_flag_wr & b_data[3])) | (b_pop & ab_empty);
         a_msg_irq <= ~ba_empty & a_en[0];
         b_msg_irq <= ~ab_empty & b_en[0];
         a_ack_irq <= (a_ack | a_ovf | a_unf) & a_en[1];
         b_ack_irq <= (b_ack | b_ovf | b_unf) & b_en[1];
      end
   end

   // ---------------- read mux ----------------
   function automatic logic [31:0] reg_read(
      input logic [3:0]  idx,
      input logic        rx_empty,
      input ptr_t        rx_count,
      input logic        tx_full,
      input ptr_t        tx_count,
      input logic [1:0]  en,
      input logic [3:0]  flags,
      input msg_t        head,
      input logic [31:0] peer
   );
      logic [31:0] r;
      logic [4:0]  rx_c5;
      logic [4:0]  tx_free5;
      r        = 32'd0;
      rx_c5    = 5'(rx_count);
      tx_free5 = DEPTH5 - 5'(tx_count);
      unique case (1'b1)
         idx == 4'h0: r = 32'd2;
         idx == 4'h1: r = {11'd0, tx_free5, 3'd0, rx_c5,
                           6'd0, tx_full, ~rx_empty};
         idx == 4'h2: r = peer;
         idx == 4'h3: r = {16'd0, DEPTH8, NWORDS8};
         idx == 4'h6: r = {30'd0, en};
         idx == 4'h7: r = {28'd0, flags};
         idx[3]: begin
            if (!rx_empty && in_msg(idx)) r = head[idx[WW-1:0]];
         end
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   logic [31:0] a_rd_val, b_rd_val;

   assign a_rd_val = reg_read(a_idx, ba_empty, ba_count, ab_full, ab_count,
                              a_en, {a_unf, a_ovf, a_ack, ~ba_empty},
                              ba_mem[ba_rptr[PW-1:0]], 32'(B_HART_ID));
   assign b_rd_val = reg_read(b_idx, ab_empty, ab_count, ba_full, ba_count,
                              b_en, {b_unf, b_ovf, b_ack, ~ab_empty},
                              ab_mem[ab_rptr[PW-1:0]], 32'(A_HART_ID));

   assign a_rdata = (a_req && !a_is_wr) ? a_rd_val : 32'd0;
   assign b_rdata = (b_req && !b_is_wr) ? b_rd_val : 32'd0;

endmodule

// File: tb/tb_mailbox_fifo_ctrl.sv
// tb_mailbox_fifo_ctrl: directed bench for mailbox_fifo_ctrl,
// register vectors from a table plus hand-written queueing sequences.
module tb_mailbox_fifo_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        a_write_in, a_read_in, b_write_in, b_read_in;
   logic [5:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_ready, b_ready;
   logic [31:0] a_rdata, b_rdata;
   logic        a_msg_irq, a_ack_irq, b_msg_irq, b_ack_irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mailbox_fifo_ctrl dut (
      .clk        (clk),
      .resetn     (resetn),
      .a_write_in (a_write_in),
      .a_read_in  (a_read_in),
      .a_addr     (a_addr),
      .a_wdata    (a_wdata),
      .a_ready    (a_ready),
      .a_rdata    (a_rdata),
      .a_msg_irq  (a_msg_irq),
      .a_ack_irq  (a_ack_irq),
      .b_write_in (b_write_in),
      .b_read_in  (b_read_in),
      .b_addr     (b_addr),
      .b_wdata    (b_wdata),
      .b_ready    (b_ready),
      .b_rdata    (b_rdata),
      .b_msg_irq  (b_msg_irq),
      .b_ack_irq  (b_ack_irq)
   );

   typedef struct {
      bit          side;
      bit          wr;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      bit          chk_irq;
      logic [3:0]  irqs;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit s, bit w, logic [5:0] a, logic [31:0] d,
                               logic [31:0] e, bit ci = 0,
                               logic [3:0] iq = 4'h0);
      vec_t v;
      v.side = s; v.wr = w; v.addr = a; v.wdata = d;
      v.exp = e; v.chk_irq = ci; v.irqs = iq;
      return v;
   endfunction

   function automatic logic [3:0] irqs_now();
      return {a_msg_irq, a_ack_irq, b_msg_irq, b_ack_irq};
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic acc(input bit side, input bit wr, input logic [5:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd);
      int n;
      bit got;
      @(negedge clk);
      if (side) begin
         b_addr = addr; b_wdata = wd; b_write_in = wr; b_read_in = !wr;
      end else begin
         a_addr = addr; a_wdata = wd; a_write_in = wr; a_read_in = !wr;
      end
      n = 0; got = 0; rd = '0;
      while (!got && n < 8) begin
         @(posedge clk); #1; n++;
         if (side ? b_ready : a_ready) begin
            got = 1;
            rd = side ? b_rdata : a_rdata;
         end
      end
      if (!got) check("ready timeout", 32'd0, 32'd1);
      else check("ready latency", n, 32'd1);
      a_write_in = 0; a_read_in = 0; b_write_in = 0; b_read_in = 0;
      @(posedge clk); #1;
   endtask

   task automatic both(input logic [5:0] aa, input logic [5:0] ba);
      @(negedge clk);
      a_addr = aa; b_addr = ba; a_wdata = '0; b_wdata = '0;
      a_write_in = 1; b_write_in = 1;
      @(posedge clk); #1;
      check("dual a_ready", a_ready, 32'd1);
      check("dual b_ready", b_ready, 32'd1);
      a_write_in = 0; b_write_in = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int p0, p1;
      resetn = 0;
      a_write_in = 0; a_read_in = 0; a_addr = '0; a_wdata = '0;
      b_write_in = 0; b_read_in = 0; b_addr = '0; b_wdata = '0;

      // A=0, B=1 ; irqs = {a_msg, a_ack, b_msg, b_ack}
      vecs.push_back(mk(0, 0, 6'h00, 0, 32'd2));
      vecs.push_back(mk(0, 0, 6'h08, 0, 32'd1));
      vecs.push_back(mk(0, 0, 6'h0C, 0, 32'h0404));
      vecs.push_back(mk(1, 0, 6'h08, 0, 32'd0));
      vecs.push_back(mk(1, 0, 6'h0C, 0, 32'h0404));
      vecs.push_back(mk(0, 0, 6'h04, 0, 32'h0004_0000));
      vecs.push_back(mk(0, 1, 6'h00, 32'h55, 0));
      vecs.push_back(mk(0, 0, 6'h00, 0, 32'd2));
      vecs.push_back(mk(0, 1, 6'h20, 32'h11, 0));
      vecs.push_back(mk(0, 1, 6'h24, 32'h22, 0));
      vecs.push_back(mk(0, 1, 6'h28, 32'h33, 0));
      vecs.push_back(mk(0, 1, 6'h2C, 32'h44, 0));
      vecs.push_back(mk(0, 1, 6'h30, 32'hDEAD_BEEF, 0));
      vecs.push_back(mk(0, 1, 6'h10, 0, 0));
      vecs.push_back(mk(1, 1, 6'h18, 32'd3, 0, 1, 4'b0010));
      vecs.push_back(mk(0, 1, 6'h18, 32'd2, 0, 1, 4'b0010));
      vecs.push_back(mk(1, 0, 6'h04, 0, 32'h0004_0101));
      vecs.push_back(mk(0, 0, 6'h04, 0, 32'h0003_0000));
      vecs.push_back(mk(1, 0, 6'h20, 0, 32'h11));
      vecs.push_back(mk(1, 0, 6'h24, 0, 32'h22));
      vecs.push_back(mk(1, 0, 6'h28, 0, 32'h33));
      vecs.push_back(mk(1, 0, 6'h2C, 0, 32'h44));
      vecs.push_back(mk(1, 0, 6'h30, 0, 32'h0));
      vecs.push_back(mk(1, 0, 6'h3C, 0, 32'h0));
      vecs.push_back(mk(1, 0, 6'h1C, 0, 32'h1));
      vecs.push_back(mk(1, 0, 6'h18, 0, 32'h3));
      vecs.push_back(mk(1, 1, 6'h14, 0, 0, 1, 4'b0100));
      vecs.push_back(mk(0, 0, 6'h1C, 0, 32'h2));
      vecs.push_back(mk(1, 0, 6'h1C, 0, 32'h0));
      vecs.push_back(mk(1, 0, 6'h20, 0, 32'h0));
      vecs.push_back(mk(0, 1, 6'h1C, 32'h2, 0, 1, 4'b0000));
      vecs.push_back(mk(0, 0, 6'h1C, 0, 32'h0));

      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1;
      #1;
      check("reset a_ready", a_ready, 0);
      check("reset b_ready", b_ready, 0);
      check("reset a_rdata", a_rdata, 0);
      check("reset b_rdata", b_rdata, 0);
      check("reset irqs", {28'd0, irqs_now()}, 0);

      // Single-cycle pulse, held strobe does not retrigger.
      @(negedge clk);
      a_addr = 6'h00; a_read_in = 1;
      @(posedge clk); #1;
      check("pulse rise", a_ready, 1);
      check("pulse data", a_rdata, 32'd2);
      @(posedge clk); #1;
      check("pulse fall", a_ready, 0);
      @(posedge clk); #1;
      check("held strobe", a_ready, 0);
      a_read_in = 0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         acc(vecs[i].side, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd);
         if (!vecs[i].wr)
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
         if (vecs[i].chk_irq) begin
            cyc(3);
            check($sformatf("vec%0d irqs", i), {28'd0, irqs_now()},
                  {28'd0, vecs[i].irqs});
         end
      end

      // Overflow: five commits into a depth-4 queue.
      for (int m = 1; m <= 5; m++) begin
         for (int k = 0; k < 4; k++)
            acc(0, 1, 6'(6'h20 + 4 * k), 32'h100 * m + k, rd);
         acc(0, 1, 6'h10, 0, rd);
      end
      acc(0, 0, 6'h04, 0, rd); check("ovf a status", rd, 32'h0000_0002);
      acc(0, 0, 6'h1C, 0, rd); check("ovf a flags", rd, 32'h4);
      acc(1, 0, 6'h04, 0, rd); check("ovf b status", rd, 32'h0004_0401);
      for (int m = 1; m <= 4; m++) begin
         for (int k = 0; k < 4; k++) begin
            acc(1, 0, 6'(6'h20 + 4 * k), 0, rd);
            check($sformatf("order m%0d w%0d", m, k), rd, 32'h100 * m + k);
         end
         acc(1, 1, 6'h14, 0, rd);
      end
      acc(1, 0, 6'h04, 0, rd); check("drained b status", rd, 32'h0004_0000);
      acc(0, 0, 6'h1C, 0, rd); check("ack+ovf a flags", rd, 32'h6);
      acc(0, 1, 6'h1C, 32'h6, rd);
      acc(0, 0, 6'h1C, 0, rd); check("w1c a flags", rd, 32'h0);

      // Underflow on empty RX queue.
      acc(1, 1, 6'h14, 0, rd);
      acc(1, 0, 6'h1C, 0, rd); check("unf b flags", rd, 32'h8);
      acc(1, 0, 6'h04, 0, rd); check("unf b status", rd, 32'h0004_0000);
      acc(1, 0, 6'h20, 0, rd); check("unf head", rd, 32'h0);
      cyc(3);
      check("unf irqs", {28'd0, irqs_now()}, 32'b0001);
      acc(1, 1, 6'h1C, 32'h8, rd);

      // Simultaneous commit and pop, second fill crosses the wrap.
      for (int m = 0; m < 4; m++) acc(0, 1, 6'h10, 0, rd);
      acc(0, 0, 6'h04, 0, rd); check("refill a status", rd, 32'h0000_0002);
      both(6'h10, 6'h14);
      acc(1, 0, 6'h04, 0, rd); check("full race count", rd, 32'h0004_0301);
      acc(0, 0, 6'h1C, 0, rd); check("full race flags", rd, 32'h6);
      acc(1, 1, 6'h14, 0, rd);
      both(6'h10, 6'h14);
      acc(1, 0, 6'h04, 0, rd); check("mid race count", rd, 32'h0004_0201);
      acc(0, 0, 6'h04, 0, rd); check("mid race a status", rd, 32'h0002_0000);

      // Reset while a read is in flight.
      @(negedge clk);
      a_addr = 6'h00; a_read_in = 1;
      #2 resetn = 0;
      p0 = 0; p1 = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (a_ready) p0++;
      end
      @(negedge clk);
      resetn = 1;
      repeat (4) begin
         @(posedge clk); #1;
         if (a_ready) p1++;
      end
      check("ready in reset", p0, 0);
      check("ready after release", p1, 1);
      a_read_in = 0;
      @(posedge clk); #1;
      acc(1, 0, 6'h04, 0, rd); check("post-reset b status", rd, 32'h0004_0000);
      acc(0, 0, 6'h04, 0, rd); check("post-reset a status", rd, 32'h0004_0000);
      acc(0, 0, 6'h1C, 0, rd); check("post-reset a flags", rd, 32'h0);
      check("post-reset irqs", {28'd0, irqs_now()}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mailbox_fifo_ctrl.md
Name: mailbox_fifo_ctrl

Overview:
Dual-port inter-hart mailbox with one queue per direction (A->B, B->A).
Each queue holds FIFO_DEPTH messages of MSG_WORDS 32-bit words. A sender stages words, then commits; the receiver reads the head message, then pops.
Per-side interrupt enables, sticky ack, overflow and underflow flags.
Sits on the fabric register bus between two MSS harts. Successor to the single-slot mailbox: parametrised depth and width, with queueing.

Parameters:
MSG_WORDS, 4, words per message; 1..8.
FIFO_DEPTH, 4, messages per direction; power of 2, 2..16.
A_HART_ID, 0, hart ID reported to side B as peer.
B_HART_ID, 1, hart ID reported to side A as peer.

Ports:
clk  in  1  system clock, single domain
resetn  in  1  asynchronous active-low reset
a_write_in  in  1  side A write strobe, held until a_ready
a_read_in  in  1  side A read strobe, held until a_ready
a_addr  in  6  side A byte address
a_wdata  in  32  side A write data
a_ready  out  1  side A access complete, 1-cycle pulse
a_rdata  out  32  side A read data, valid with a_ready
a_msg_irq  out  1  side A RX message available & enabled
a_ack_irq  out  1  side A sticky ack/error & enabled
b_* (b_write_in, b_read_in, b_addr, b_wdata, b_ready, b_rdata, b_msg_irq, b_ack_irq)  mirror of side A

Behaviour:
- Reset: clk is the single clock; resetn is asynchronous, active-low.
  - All outputs 0, both FIFOs empty (pointers 0), staging buffers 0, enables 0, sticky flags 0.
  - Reset mid-access aborts the access with no ready pulse and no side effect.
- Access handshake, per side:
  - Strobe sampled high while idle -> ready high exactly 1 cycle later, for 1 cycle.
  - Side effect occurs once, in the cycle ready is driven.
  - Side stays busy until its strobe drops; a held strobe never re-triggers.
  - Read and write both high: write wins.
  - Unmapped address: ready still pulses, rdata 0, no effect.
- Register map (addr[5:2]):
  - 0x0 VERSION: RO 2.
  - 0x1 STATUS: RO. [0] rx_nonempty, [1] tx_full, [12:8] rx_count, [20:16] tx_free.
  - 0x2 PEER_ID: RO.
  - 0x3 PARAMS: RO {FIFO_DEPTH[15:8], MSG_WORDS[7:0]}.
  - 0x4 TX_COMMIT: WO, data ignored.
  - 0x5 RX_POP: WO, data ignored.
  - 0x6 IRQ_EN: RW [1:0].
  - 0x7 IRQ_FLAGS: [0] rx_avail RO level, [1] ack, [2] overflow, [3] underflow; bits [3:1] W1C.
  - 0x8-0xF: write = staging word addr[4:2]; read = RX head word addr[4:2].
  - Word index >= MSG_WORDS: write ignored, read returns 0.
- TX_COMMIT:
  - Not full: copies the whole staging buffer into the peer-bound FIFO tail in one cycle; wptr+1; staging retained.
  - Full: message dropped, overflow flag set.
- RX_POP:
  - Non-empty: rptr+1; peer's ack flag set.
  - Empty: no pointer change, underflow flag set.
- Reading head words while the RX FIFO is empty returns 0. Head reads are non-destructive.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits with wrap bit.
  - full = MSBs differ and LSBs equal.
  - count = wptr - rptr modulo 2^(log2+1).
- Same FIFO, same cycle: commit by sender and pop by receiver both take effect; count unchanged.
  - Commit when full plus simultaneous pop: commit dropped (full evaluated pre-pop); pop succeeds.
- W1C of ack in the same cycle as a new ack set: the flag remains set.
- Interrupt outputs, registered, 1-cycle latency from flag change:
  - msg_irq = rx_avail & en[0].
  - ack_irq = (ack | overflow | underflow) & en[1].

Test Plan:
- Reset, then A reads VERSION/PEER_ID/PARAMS -> 2, 1, 0x0404; all irqs 0; a_ready single-cycle pulse one cycle after strobe.
- A writes words 0..3 = 0x11,0x22,0x33,0x44 then commits; B IRQ_EN=3 -> b_msg_irq=1; B STATUS rx_count=1; B reads 0x20..0x2C -> 0x11..0x44; B pops -> b_msg_irq=0, A IRQ_FLAGS[1]=1, a_ack_irq=1 (A IRQ_EN=2); A W1C 0x2 clears it.
- A commits 5 distinct messages with depth 4 -> 5th dropped, A overflow=1, tx_full=1; B pops 4 and gets messages 1..4 in order, with pointer wrap exercised across two fill cycles.
- B pops on empty FIFO -> underflow=1, rx_count=0, head reads 0.
- FIFO full; A commit and B pop in the same cycle -> pop succeeds, commit dropped, count 3; FIFO at count 2 with simultaneous commit and pop -> count stays 2.
- resetn asserted with a_read_in held mid-access -> no a_ready pulse; FIFOs empty after deassertion; held strobe after release produces exactly one ready.
